ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM pipeline register of the 5-stage MIPS core; captures ALU outputs (result, zero, overflow) plus EX control.
//  Resolves beq (taken pulse) and raises a precise arithmetic-overflow exception on trapping add/sub.
//  An overflowing instruction's side effects are squashed.
//  Exception FSM holds the request until acknowledged; backpressures EX via ex_ready.
// PARAMETERS
//  DATA_W      32  datapath width (ALU result, store data, PC)
//  REG_AW      5   register-file address width
//  CNT_W       8   width of saturating overflow-exception counter
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous, active-low reset
//  ex_valid         in   1       EX holds a valid instruction
//  ex_pc            in   DATA_W  PC of the EX instruction
//  ex_alu_result    in   DATA_W  ALU result
//  ex_alu_zero      in   1       ALU zero flag
//  ex_alu_overflow  in   1       ALU signed-overflow flag
//  ex_ovf_trap_en   in   1       1 = add/sub (trapping); 0 = addu/subu/logic
//  ex_store_data    in   DATA_W  rt value for sw
//  ex_rd            in   REG_AW  destination register
//  ex_reg_write     in   1       writeback enable
//  ex_mem_read      in   1       lw
//  ex_mem_write     in   1       sw
//  ex_mem_to_reg    in   1       writeback source = memory
//  ex_branch        in   1       beq in EX
//  ex_branch_target in   DATA_W  computed branch target
//  stall            in   1       MEM stage busy; hold register
//  flush            in   1       squash instruction being captured
//  exc_ack          in   1       exception serviced
//  ex_ready         out  1       EX may advance = (state==RUN) & !stall
//  mem_valid        out  1       MEM holds a valid instruction
//  mem_alu_result   out  DATA_W  registered ALU result (memory address / wb data)
//  mem_store_data   out  DATA_W  registered store data
//  mem_rd           out  REG_AW  registered destination
//  mem_reg_write    out  1       registered control, forced 0 when !mem_valid
//  mem_mem_read     out  1       ditto
//  mem_mem_write    out  1       ditto
//  mem_mem_to_reg   out  1       ditto
//  branch_taken     out  1       one-cycle pulse: beq taken
//  branch_target    out  DATA_W  registered target, valid with branch_taken
//  exc_req          out  1       overflow exception pending (level)
//  exc_epc          out  DATA_W  PC of the overflowing instruction
//  exc_count        out  CNT_W   overflow exceptions taken; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN; every output 0, including data fields, exc_epc and exc_count.
//  Latency: 1 cycle EX->MEM. "capture" = RUN & !stall at a rising edge.
//  States: RUN, TRAP. RUN->TRAP on capture with trap = ex_valid & ex_ovf_trap_en & ex_alu_overflow & !flush.
//    TRAP->RUN on the edge where exc_ack=1; exc_ack ignored in RUN.
//  On capture: data fields load unconditionally; mem_valid <= ex_valid & !flush & !trap.
//    Control outputs are the EX values gated by that next mem_valid.
//  On trap: exc_req<=1, exc_epc<=ex_pc, exc_count<=exc_count+1 (saturating); mem_valid<=0 so no reg or memory write.
//  TRAP: mem_valid and branch_taken held 0; ex_ready=0; exc_req stays 1 until the ack edge, then 0.
//  Branch: branch_taken <= capture & ex_valid & ex_branch & ex_alu_zero & !flush & !trap; cleared on every other edge.
//    branch_target loads on capture.
//  Stall in RUN (no capture): all mem_* hold; branch_taken<=0, so no repeated pulse.
//  stall & flush together: flush wins; mem_valid<=0, other mem_* hold.
//  flush in TRAP: no effect; stays TRAP.
//  Unsigned ops (ex_ovf_trap_en=0) with overflow=1 proceed normally; no exception.
//  exc_ack & new EX data on the same edge: only the ack is processed; ex_ready was 0.
// TESTING
//  1 add: valid, result=14, rd=5, reg_write=1 -> next cycle mem_valid=1, mem_alu_result=14, mem_rd=5, mem_reg_write=1.
//  2 add 0x7FFFFFFD+9: result=0x80000006, ovf=1, trap_en=1, pc=0x40 ->
//    mem_valid=0, mem_reg_write=0, exc_req=1, exc_epc=0x40, exc_count=1, ex_ready=0.
//    Held 3 cycles; exc_ack=1 -> exc_req=0, ex_ready=1 next cycle.
//  3 addu, same operands, trap_en=0 -> mem_valid=1, mem_alu_result=0x80000006, exc_req=0, exc_count unchanged.
//  4 beq: zero=1, target=0x100 -> branch_taken=1 for exactly 1 cycle, branch_target=0x100; beq with zero=0 -> no pulse.
//  5 stall=1 for 2 cycles with new EX data -> mem_* unchanged, branch_taken=0.
//    stall=1 & flush=1 -> mem_valid=0.
//  6 rst_n=0 mid-TRAP (async, between edges) -> exc_req, mem_valid, exc_count=0 immediately; RUN after release.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 5-stage MIPS core.
// Captures ALU outputs and EX control, resolves beq and raises precise overflow exceptions.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_alu_zero,
    input  logic              ex_alu_overflow,
    input  logic              ex_ovf_trap_en,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_branch,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic              stall,
    input  logic              flush,
    input  logic              exc_ack,
    output logic              ex_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              exc_req,
    output logic [DATA_W-1:0] exc_epc,
    output logic [CNT_W-1:0]  exc_count
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t state;

    logic capture;
    logic trap;
    logic next_valid;
    logic take_branch;

    assign capture     = (state == RUN) && !stall;
    assign trap        = ex_valid && ex_ovf_trap_en && ex_alu_overflow && !flush;
    assign next_valid  = ex_valid && !flush && !trap;
    assign take_branch = ex_valid && ex_branch && ex_alu_zero && !flush && !trap;
    assign ex_ready    = capture;

    // Control outputs are stored already gated by mem_valid, so whenever
    // mem_valid drops the write enables drop with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            branch_taken   <= 1'b0;
            branch_target  <= '0;
            exc_req        <= 1'b0;
            exc_epc        <= '0;
            exc_count      <= '0;
        end else begin
            branch_taken <= 1'b0;
            case (state)
                RUN: begin
                    if (capture) begin
                        mem_alu_result <= ex_alu_result;
                        mem_store_data <= ex_store_data;
                        mem_rd         <= ex_rd;
                        branch_target  <= ex_branch_target;
                        mem_valid      <= next_valid;
                        mem_reg_write  <= ex_reg_write  && next_valid;
                        mem_mem_read   <= ex_mem_read   && next_valid;
                        mem_mem_write  <= ex_mem_write  && next_valid;
                        mem_mem_to_reg <= ex_mem_to_reg && next_valid;
                        branch_taken   <= take_branch;
                        if (trap) begin
                            state   <= TRAP;
                            exc_req <= 1'b1;
                            exc_epc <= ex_pc;
                            if (exc_count != '1) begin
                                exc_count <= exc_count + CNT_W'(1);
                            end
                        end
                    end else if (flush) begin
                        // Stalled flush: kill the held instruction but keep its data.
                        mem_valid      <= 1'b0;
                        mem_reg_write  <= 1'b0;
                        mem_mem_read   <= 1'b0;
                        mem_mem_write  <= 1'b0;
                        mem_mem_to_reg <= 1'b0;
                    end
                end
                TRAP: begin
                    mem_valid      <= 1'b0;
                    mem_reg_write  <= 1'b0;
                    mem_mem_read   <= 1'b0;
                    mem_mem_write  <= 1'b0;
                    mem_mem_to_reg <= 1'b0;
                    if (exc_ack) begin
                        state   <= RUN;
                        exc_req <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: ALU capture, overflow trap, beq, stall/flush, reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_result;
    logic        ex_alu_zero;
    logic        ex_alu_overflow;
    logic        ex_ovf_trap_en;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic [31:0] ex_branch_target;
    logic        stall;
    logic        flush;
    logic        exc_ack;
    logic        ex_ready;
    logic        mem_valid;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_mem_to_reg;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc_req;
    logic [31:0] exc_epc;
    logic [7:0]  exc_count;

    int check_count = 0;
    int pass_count  = 0;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_alu_zero(ex_alu_zero), .ex_alu_overflow(ex_alu_overflow),
        .ex_ovf_trap_en(ex_ovf_trap_en), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_branch_target(ex_branch_target),
        .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .ex_ready(ex_ready), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .branch_taken(branch_taken),
        .branch_target(branch_target), .exc_req(exc_req),
        .exc_epc(exc_epc), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_pc = 0; ex_alu_result = 0; ex_alu_zero = 0;
        ex_alu_overflow = 0; ex_ovf_trap_en = 0; ex_store_data = 0; ex_rd = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        ex_branch = 0; ex_branch_target = 0;
    endtask

    task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] result, input logic [4:0] rd,
                                  input logic reg_write, input logic ovf, input logic trap_en);
        clear_ex();
        ex_valid = 1; ex_pc = pc; ex_alu_result = result; ex_rd = rd;
        ex_reg_write = reg_write; ex_alu_overflow = ovf; ex_ovf_trap_en = trap_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; exc_ack = 0;
        clear_ex();
        #2;
        check_output("reset_mem_valid", 32'(mem_valid), 0);
        check_output("reset_alu_result", mem_alu_result, 0);
        check_output("reset_exc_req", 32'(exc_req), 0);
        check_output("reset_exc_count", 32'(exc_count), 0);
        check_output("reset_branch_target", branch_target, 0);
        #10 rst_n = 1;

        // add: result 14 into r5
        apply_stimulus(32'h10, 32'd14, 5'd5, 1, 0, 1);
        ex_store_data = 32'h1234;
        tick();
        check_output("add_mem_valid", 32'(mem_valid), 1);
        check_output("add_result", mem_alu_result, 14);
        check_output("add_rd", 32'(mem_rd), 5);
        check_output("add_reg_write", 32'(mem_reg_write), 1);
        check_output("add_store_data", mem_store_data, 32'h1234);
        check_output("add_ex_ready", 32'(ex_ready), 1);

        // trapping add overflows
        apply_stimulus(32'h40, 32'h80000006, 5'd7, 1, 1, 1);
        tick();
        check_output("trap_mem_valid", 32'(mem_valid), 0);
        check_output("trap_reg_write", 32'(mem_reg_write), 0);
        check_output("trap_exc_req", 32'(exc_req), 1);
        check_output("trap_epc", exc_epc, 32'h40);
        check_output("trap_count", 32'(exc_count), 1);
        check_output("trap_ex_ready", 32'(ex_ready), 0);
        check_output("trap_result_loaded", mem_alu_result, 32'h80000006);

        apply_stimulus(32'h44, 32'h99, 5'd9, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            check_output("trap_hold_exc_req", 32'(exc_req), 1);
            check_output("trap_hold_mem_valid", 32'(mem_valid), 0);
            check_output("trap_hold_result", mem_alu_result, 32'h80000006);
        end
        flush = 0;
        exc_ack = 1;
        tick();
        exc_ack = 0;
        check_output("ack_exc_req", 32'(exc_req), 0);
        check_output("ack_ex_ready", 32'(ex_ready), 1);
        check_output("ack_mem_valid", 32'(mem_valid), 0);
        check_output("ack_no_capture", mem_alu_result, 32'h80000006);
        check_output("ack_epc_kept", exc_epc, 32'h40);

        // addu with overflow: no trap
        apply_stimulus(32'h48, 32'h80000006, 5'd8, 1, 1, 0);
        tick();
        check_output("addu_mem_valid", 32'(mem_valid), 1);
        check_output("addu_result", mem_alu_result, 32'h80000006);
        check_output("addu_exc_req", 32'(exc_req), 0);
        check_output("addu_count", 32'(exc_count), 1);
        check_output("addu_reg_write", 32'(mem_reg_write), 1);

        // beq taken, then a non-branch, then beq not taken
        apply_stimulus(32'h4C, 32'h0, 5'd0, 0, 0, 0);
        ex_branch = 1; ex_alu_zero = 1; ex_branch_target = 32'h100;
        tick();
        check_output("beq_taken", 32'(branch_taken), 1);
        check_output("beq_target", branch_target, 32'h100);
        check_output("beq_reg_write", 32'(mem_reg_write), 0);
        apply_stimulus(32'h50, 32'h20, 5'd3, 1, 0, 0);
        tick();
        check_output("beq_pulse_end", 32'(branch_taken), 0);
        apply_stimulus(32'h54, 32'h4, 5'd0, 0, 0, 0);
        ex_branch = 1; ex_alu_zero = 0; ex_branch_target = 32'h200;
        tick();
        check_output("beq_not_taken", 32'(branch_taken), 0);
        check_output("beq_nt_target", branch_target, 32'h200);

        // lw loaded, then stalled with new data
        apply_stimulus(32'h58, 32'h55, 5'd9, 1, 0, 0);
        ex_mem_read = 1; ex_mem_to_reg = 1;
        tick();
        check_output("lw_mem_read", 32'(mem_mem_read), 1);
        check_output("lw_mem_to_reg", 32'(mem_mem_to_reg), 1);
        check_output("lw_mem_write", 32'(mem_mem_write), 0);
        apply_stimulus(32'h5C, 32'hAA, 5'd10, 0, 0, 0);
        ex_branch = 1; ex_alu_zero = 1; ex_mem_write = 1;
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("stall_result", mem_alu_result, 32'h55);
            check_output("stall_rd", 32'(mem_rd), 9);
            check_output("stall_mem_valid", 32'(mem_valid), 1);
            check_output("stall_mem_write", 32'(mem_mem_write), 0);
            check_output("stall_branch", 32'(branch_taken), 0);
            check_output("stall_ex_ready", 32'(ex_ready), 0);
        end
        flush = 1;
        tick();
        check_output("stallflush_valid", 32'(mem_valid), 0);
        check_output("stallflush_reg_write", 32'(mem_reg_write), 0);
        check_output("stallflush_result", mem_alu_result, 32'h55);
        stall = 0; flush = 0;

        // async reset in the middle of a trap
        apply_stimulus(32'h80, 32'h80000000, 5'd4, 1, 1, 1);
        tick();
        check_output("trap2_count", 32'(exc_count), 2);
        check_output("trap2_exc_req", 32'(exc_req), 1);
        clear_ex();
        #2 rst_n = 0;
        #1;
        check_output("async_exc_req", 32'(exc_req), 0);
        check_output("async_mem_valid", 32'(mem_valid), 0);
        check_output("async_count", 32'(exc_count), 0);
        check_output("async_epc", exc_epc, 0);
        #1 rst_n = 1;
        tick();
        check_output("post_reset_ready", 32'(ex_ready), 1);
        apply_stimulus(32'h84, 32'h77, 5'd2, 1, 0, 0);
        tick();
        check_output("post_reset_capture", 32'(mem_valid), 1);
        check_output("post_reset_result", mem_alu_result, 32'h77);

        // counter saturation over many trap/ack pairs
        for (int i = 0; i < 257; i++) begin
            apply_stimulus(32'h100 + 32'(i), 32'h0, 5'd1, 1, 1, 1);
            tick();
            clear_ex();
            exc_ack = 1;
            tick();
            exc_ack = 0;
        end
        check_output("sat_count", 32'(exc_count), 255);
        check_output("sat_epc", exc_epc, 32'h200);
        check_output("sat_ready", 32'(ex_ready), 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
